// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-code LED path: the monitor state encoding
// and the default widths used by the decoder and the monitor.
// ---------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_N      = 4;  // Gray input / binary output width
    localparam int GRAY_WRAP_W = 8;  // net wrap counter width
    localparam int GRAY_ERR_W  = 8;  // saturating fault counter width

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,  // waiting for the first sample after reset
        ST_TRACK = 2'd1,  // locked, checking every change is a +/-1 step
        ST_FAULT = 2'd2   // illegal step seen, waiting for a stable value
    } state_t;

endpackage

// File: rtl/gray_to_bin.sv
// ---------------------------------------------------------------------------
// gray_to_bin
// Purely combinational Gray-to-binary decode. Each binary bit is the XOR of
// all Gray bits at or above its position, so the MSB passes straight through.
//
// Ports:
//   gray_in  [N-1:0]  Gray-coded value
//   bin_out  [N-1:0]  binary equivalent
// ---------------------------------------------------------------------------
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int N = GRAY_N
) (
    input  logic [N-1:0] gray_in,
    output logic [N-1:0] bin_out
);

    // The reduction form avoids the ripple chain b[i] = b[i+1] ^ g[i] as an
    // explicit dependency; synthesis rebalances it either way.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin_out[i] = ^gray_in[N-1:i];
    end

endmodule

// File: rtl/gray_decoder_monitor.sv
// ---------------------------------------------------------------------------
// gray_decoder_monitor
// Reader side of the Gray-counter LED path. Synchronises an asynchronous
// Gray bus, decodes it on each sample strobe and checks that every accepted
// change is a legal +/-1 step. Reports direction pulses, keeps a net
// wrap-around count and a saturating fault count, and re-locks after a fault
// once two consecutive samples agree.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   gray_in     [N-1:0]       Gray-coded value, may be asynchronous to clk
//   sample_en   sample strobe, one sample per cycle while high
//   bin_out     [N-1:0]       decoded binary of the last accepted sample
//   valid       high while locked (TRACK)
//   step_up     one-cycle pulse on a legal +1 step
//   step_down   one-cycle pulse on a legal -1 step
//   err         one-cycle pulse on an illegal transition
//   wrap_count  [WRAP_W-1:0]  net wrap count, modulo 2^WRAP_W
//   err_count   [ERR_W-1:0]   illegal-transition count, saturating
// ---------------------------------------------------------------------------
module gray_decoder_monitor
    import gray_pkg::*;
#(
    parameter int N      = GRAY_N,
    parameter int WRAP_W = GRAY_WRAP_W,
    parameter int ERR_W  = GRAY_ERR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      gray_in,
    input  logic              sample_en,
    output logic [N-1:0]      bin_out,
    output logic              valid,
    output logic              step_up,
    output logic              step_down,
    output logic              err,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [N-1:0]     BIN_MAX = {N{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t            state_q, state_d;
    logic [N-1:0]      sync1_q, sync1_d;
    logic [N-1:0]      sync2_q, sync2_d;
    logic [N-1:0]      bin_q, bin_d;
    logic [N-1:0]      ref_q, ref_d;
    logic [N-1:0]      cand_q, cand_d;
    logic              valid_q, valid_d;
    logic              up_q, up_d;
    logic              down_q, down_d;
    logic              err_q, err_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [ERR_W-1:0]  errc_q, errc_d;

    logic [N-1:0]      b;
    logic [N-1:0]      ref_plus, ref_minus;

    gray_to_bin #(.N(N)) u_dec (
        .gray_in (sync2_q),
        .bin_out (b)
    );

    assign ref_plus  = ref_q + N'(1);
    assign ref_minus = ref_q - N'(1);

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned; that is what keeps this block free of latches.
        sync1_d = gray_in;
        sync2_d = sync1_q;
        state_d = state_q;
        bin_d   = bin_q;
        ref_d   = ref_q;
        cand_d  = cand_q;
        valid_d = valid_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        err_d   = 1'b0;
        wrap_d  = wrap_q;
        errc_d  = errc_q;

        if (sample_en) begin
            unique case (state_q)
                ST_INIT: begin
                    bin_d   = b;
                    ref_d   = b;
                    valid_d = 1'b1;
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (b == ref_q) begin
                        // Unchanged sample: nothing to report.
                    end else if (b == ref_plus) begin
                        // Tested before -1 so that with N = 1, where +1 and
                        // -1 coincide, the change is reported as step_up.
                        up_d  = 1'b1;
                        bin_d = b;
                        ref_d = b;
                        if (ref_q == BIN_MAX) wrap_d = wrap_q + WRAP_W'(1);
                    end else if (b == ref_minus) begin
                        down_d = 1'b1;
                        bin_d  = b;
                        ref_d  = b;
                        if (ref_q == '0) wrap_d = wrap_q - WRAP_W'(1);
                    end else begin
                        // bin_out keeps the last good value through the fault.
                        err_d   = 1'b1;
                        cand_d  = b;
                        valid_d = 1'b0;
                        state_d = ST_FAULT;
                        if (errc_q != ERR_MAX) errc_d = errc_q + ERR_W'(1);
                    end
                end
                ST_FAULT: begin
                    // Re-lock only once the same value is seen twice in a row.
                    if (b == cand_q) begin
                        bin_d   = b;
                        ref_d   = b;
                        valid_d = 1'b1;
                        state_d = ST_TRACK;
                    end else begin
                        cand_d = b;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // rather than in the sensitivity list, and it overrides any sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            sync1_q <= '0;
            sync2_q <= '0;
            bin_q   <= '0;
            ref_q   <= '0;
            cand_q  <= '0;
            valid_q <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= '0;
            errc_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            bin_q   <= bin_d;
            ref_q   <= ref_d;
            cand_q  <= cand_d;
            valid_q <= valid_d;
            up_q    <= up_d;
            down_q  <= down_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
            errc_q  <= errc_d;
        end
    end

    assign bin_out    = bin_q;
    assign valid      = valid_q;
    assign step_up    = up_q;
    assign step_down  = down_q;
    assign err        = err_q;
    assign wrap_count = wrap_q;
    assign err_count  = errc_q;

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// ---------------------------------------------------------------------------
// tb_gray_decoder_monitor
// Directed bench for gray_decoder_monitor with N=4, WRAP_W=8, ERR_W=8.
// A table of hand-computed vectors is applied one sample at a time, followed
// by hand-written sequences for reset, idle strobe, reset during a fault and
// fault-counter saturation.
// ---------------------------------------------------------------------------
module tb_gray_decoder_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] gray_in = '0;
    logic       sample_en = 1'b0;
    logic [3:0] bin_out;
    logic       valid, step_up, step_down, err;
    logic [7:0] wrap_count, err_count;

    int checks = 0;
    int errors = 0;

    gray_decoder_monitor #(.N(4), .WRAP_W(8), .ERR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .gray_in    (gray_in),
        .sample_en  (sample_en),
        .bin_out    (bin_out),
        .valid      (valid),
        .step_up    (step_up),
        .step_down  (step_down),
        .err        (err),
        .wrap_count (wrap_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic       valid;
        logic       up;
        logic       down;
        logic       err;
        logic [7:0] wrap;
        logic [7:0] errc;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] g, input logic [3:0] b, input logic v,
                       input logic u, input logic d, input logic e,
                       input logic [7:0] w, input logic [7:0] ec);
        vq.push_back('{gray: g, bin: b, valid: v, up: u, down: d, err: e, wrap: w, errc: ec});
    endtask

    // Change gray_in, let the two synchroniser stages settle, then strobe
    // sample_en for exactly one edge and return #1 after that edge.
    task automatic apply(input logic [3:0] g);
        @(negedge clk);
        gray_in = g;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bin_out"},    32'(bin_out), 32'h0);
        check({tag, " valid"},      32'(valid), 32'h0);
        check({tag, " pulses"},     32'({step_up, step_down, err}), 32'h0);
        check({tag, " wrap_count"}, 32'(wrap_count), 32'h0);
        check({tag, " err_count"},  32'(err_count), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        //   gray     bin    v  up dn er  wrap   errc
        add(4'b0000, 4'd0,  1, 0, 0, 0, 8'h00, 8'h00); // INIT accept
        add(4'b1000, 4'd15, 1, 0, 1, 0, 8'hFF, 8'h00); // down-wrap 0 -> 15
        add(4'b1001, 4'd14, 1, 0, 1, 0, 8'hFF, 8'h00); // plain -1
        add(4'b1000, 4'd15, 1, 1, 0, 0, 8'hFF, 8'h00); // plain +1
        add(4'b0000, 4'd0,  1, 1, 0, 0, 8'h00, 8'h00); // up-wrap back to 0
        add(4'b0001, 4'd1,  1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b0011, 4'd2,  1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b0010, 4'd3,  1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b0110, 4'd4,  1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b0111, 4'd5,  1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b0101, 4'd6,  1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b0100, 4'd7,  1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b1100, 4'd8,  1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b1101, 4'd9,  1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b1111, 4'd10, 1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b1110, 4'd11, 1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b1010, 4'd12, 1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b1011, 4'd13, 1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b1001, 4'd14, 1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b1000, 4'd15, 1, 1, 0, 0, 8'h00, 8'h00);
        add(4'b0000, 4'd0,  1, 1, 0, 0, 8'h01, 8'h00); // full cycle: wrap 1
        add(4'b0000, 4'd0,  1, 0, 0, 0, 8'h01, 8'h00); // same value, no pulse
        add(4'b0001, 4'd1,  1, 1, 0, 0, 8'h01, 8'h00);
        add(4'b0011, 4'd2,  1, 1, 0, 0, 8'h01, 8'h00);
        add(4'b0010, 4'd3,  1, 1, 0, 0, 8'h01, 8'h00);
        add(4'b0110, 4'd4,  1, 1, 0, 0, 8'h01, 8'h00);
        add(4'b0111, 4'd5,  1, 1, 0, 0, 8'h01, 8'h00); // locked at 5
        add(4'b0101, 4'd6,  1, 1, 0, 0, 8'h01, 8'h00); // +1 to 6
        add(4'b1111, 4'd6,  0, 0, 0, 1, 8'h01, 8'h01); // jump to 10: fault
        add(4'b1111, 4'd10, 1, 0, 0, 0, 8'h01, 8'h01); // stable: re-lock
        add(4'b0000, 4'd10, 0, 0, 0, 1, 8'h01, 8'h02); // 10 -> 0: fault
        add(4'b1110, 4'd10, 0, 0, 0, 0, 8'h01, 8'h02); // cand 11, no err
        add(4'b1010, 4'd10, 0, 0, 0, 0, 8'h01, 8'h02); // cand 12, no err
        add(4'b1010, 4'd12, 1, 0, 0, 0, 8'h01, 8'h02); // re-lock at 12
        add(4'b1000, 4'd12, 0, 0, 0, 1, 8'h01, 8'h03); // 1-bit Gray, 12 -> 15
        add(4'b1000, 4'd15, 1, 0, 0, 0, 8'h01, 8'h03); // re-lock at 15

        do_reset();
        #1;
        check_all_zero("reset");

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].gray);
            check($sformatf("vec%0d bin_out", i),    32'(bin_out),    32'(vq[i].bin));
            check($sformatf("vec%0d valid", i),      32'(valid),      32'(vq[i].valid));
            check($sformatf("vec%0d step_up", i),    32'(step_up),    32'(vq[i].up));
            check($sformatf("vec%0d step_down", i),  32'(step_down),  32'(vq[i].down));
            check($sformatf("vec%0d err", i),        32'(err),        32'(vq[i].err));
            check($sformatf("vec%0d wrap_count", i), 32'(wrap_count), 32'(vq[i].wrap));
            check($sformatf("vec%0d err_count", i),  32'(err_count),  32'(vq[i].errc));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d pulses clear", i), 32'({step_up, step_down, err}), 32'h0);
        end

        // Idle strobe: an illegal value (bin 2 from 15) with sample_en low
        // must change nothing.
        @(negedge clk);
        gray_in = 4'b0011;
        repeat (6) @(posedge clk);
        #1;
        check("idle bin_out",   32'(bin_out), 32'd15);
        check("idle valid",     32'(valid), 32'h1);
        check("idle pulses",    32'({step_up, step_down, err}), 32'h0);
        check("idle err_count", 32'(err_count), 32'h3);

        // Now sample it: fault.
        apply(4'b0011);
        check("fault2 err",       32'(err), 32'h1);
        check("fault2 valid",     32'(valid), 32'h0);
        check("fault2 err_count", 32'(err_count), 32'h4);

        // Reset together with sample_en while in FAULT: reset wins.
        @(negedge clk);
        rst = 1'b1;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("rst+sample");
        @(negedge clk);
        rst = 1'b0;
        sample_en = 1'b0;

        // First sample after reset is accepted unconditionally.
        apply(4'b0111);
        check("post-rst bin_out",   32'(bin_out), 32'd5);
        check("post-rst valid",     32'(valid), 32'h1);
        check("post-rst pulses",    32'({step_up, step_down, err}), 32'h0);
        check("post-rst err_count", 32'(err_count), 32'h0);

        // Saturation: 300 forced faults, alternating between bin 0 and bin 10.
        do_reset();
        apply(4'b0000);
        for (int k = 0; k < 300; k++) begin
            logic [3:0] tgt;
            tgt = (k % 2 == 0) ? 4'b1111 : 4'b0000;
            apply(tgt);
            if (k == 254) check("sat at 255 faults", 32'(err_count), 32'd255);
            if (k == 299) check("sat last err pulse", 32'(err), 32'h1);
            apply(tgt);
        end
        check("sat err_count", 32'(err_count), 32'd255);
        check("sat valid",     32'(valid), 32'h1);
        check("sat wrap",      32'(wrap_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
